// File: rtl/sram_dp_param.sv
// Parametrised synchronous dual-port SRAM: reset-driven clear, write-first bypass, RD_LAT of 1 or 2.
// Define SRAM_DP_PARITY_EN to store one even-parity bit per 64-bit lane and report errors on Perr.
module sram_dp_param #(
    parameter int  DW     = 320,
    parameter int  AW     = 7,
    parameter int  RD_LAT = 1,
    parameter real TACC   = 5.5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          W,
    input  logic          R,
    input  logic [AW-1:0] WA,
    input  logic [AW-1:0] RA,
    input  logic [DW-1:0] Din,
    output logic [DW-1:0] Dout,
    output logic          Dvalid,
    output logic          Ready,
    output logic          Perr
);
    localparam int DEPTH = 2 ** AW;
    localparam int NL    = DW / 64;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    typedef struct packed {
        logic          vld;
        logic          perr;
        logic [DW-1:0] data;
    } rd_stage_t;

    if (DW < 64 || DW % 64 != 0) begin : g_bad_dw
        $error("sram_dp_param: DW must be a positive multiple of 64");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("sram_dp_param: RD_LAT must be 1 or 2");
    end
    if (TACC < 0.0) begin : g_bad_tacc
        $error("sram_dp_param: TACC must not be negative");
    end

    state_t        r_state;
    logic [AW-1:0] r_cnt;
    logic          r_ready;
    logic          r_wr_pend;
    logic [AW-1:0] r_wa;
    logic [DW-1:0] r_wd;
    logic [DW-1:0] r_mem [DEPTH];
    rd_stage_t     r_s0;
    logic [DW-1:0] r_dout;
    logic          r_dvalid;
    logic          r_perr;

    logic          w_accept;
    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_byp;
    logic [DW-1:0] w_rd_data;
    logic          w_rd_perr;
    rd_stage_t     w_out;

    assign w_accept  = r_ready & ~RST;
    assign w_wr_en   = W & w_accept;
    assign w_rd_en   = R & w_accept;
    // A read sampled on the commit edge of the pending write must see the new word.
    assign w_byp     = r_wr_pend && (r_wa == RA);
    assign w_rd_data = w_byp ? r_wd : r_mem[RA];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            r_cnt <= r_cnt + AW'(1);
            if (&r_cnt) begin
                r_state <= ST_RUN;
                r_ready <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_pend <= 1'b0;
            r_wa      <= '0;
            r_wd      <= '0;
        end else begin
            r_wr_pend <= w_wr_en;
            if (w_wr_en) begin
                r_wa <= WA;
                r_wd <= Din;
            end
        end
    end

    // NOTE: the array has no reset branch; the CLEAR sequence zeroes it, so it still maps onto RAM.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_cnt] <= '0;
            end else if (r_wr_pend) begin
                r_mem[r_wa] <= r_wd;
            end
        end
    end

`ifdef SRAM_DP_PARITY_EN
    logic [NL-1:0] r_par [DEPTH];
    logic [NL-1:0] r_wp;
    logic [NL-1:0] w_rd_par;

    function automatic logic [NL-1:0] lane_par(input logic [DW-1:0] d);
        logic [NL-1:0] p;
        p = '0;
        for (int i = 0; i < NL; i++) begin
            p[i] = ^d[i*64 +: 64];
        end
        return p;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wp <= '0;
        end else if (w_wr_en) begin
            r_wp <= lane_par(Din);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (r_state == ST_CLEAR) begin
                r_par[r_cnt] <= '0;
            end else if (r_wr_pend) begin
                r_par[r_wa] <= r_wp;
            end
        end
    end

    assign w_rd_par  = w_byp ? r_wp : r_par[RA];
    assign w_rd_perr = |(lane_par(w_rd_data) ^ w_rd_par);
`else
    assign w_rd_perr = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s0 <= '0;
        end else begin
            r_s0.vld  <= w_rd_en;
            r_s0.perr <= w_rd_en & w_rd_perr;
            if (w_rd_en) begin
                r_s0.data <= w_rd_data;
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        rd_stage_t r_s1;

        always_ff @(posedge CLK) begin
            if (RST) begin
                r_s1 <= '0;
            end else begin
                r_s1 <= r_s0;
            end
        end

        assign w_out = r_s1;
    end else begin : g_lat1
        assign w_out = r_s0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dout   <= '0;
            r_dvalid <= 1'b0;
            r_perr   <= 1'b0;
        end else begin
            r_dvalid <= w_out.vld;
            r_perr   <= w_out.vld & w_out.perr;
            if (w_out.vld) begin
                r_dout <= w_out.data;
            end
        end
    end

    assign Dout   = r_dout;
    assign Dvalid = r_dvalid;
    assign Ready  = r_ready;
    assign Perr   = r_perr;

endmodule

// File: tb/tb_sram_dp_param.sv
// Scoreboard bench for sram_dp_param: one RD_LAT=1 and one RD_LAT=2 instance share the stimulus.
// Expected reads are queued with their due cycle when driven and compared when Dvalid fires.
module tb_sram_dp_param;
    localparam int DW    = 320;
    localparam int AW    = 7;
    localparam int DEPTH = 128;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic          perr;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          W;
    logic          R;
    logic [AW-1:0] WA;
    logic [AW-1:0] RA;
    logic [DW-1:0] Din;
    logic [DW-1:0] Dout1, Dout2;
    logic          Dvalid1, Dvalid2;
    logic          Ready1, Ready2;
    logic          Perr1, Perr2;

    int            n_checks = 0;
    int            n_errs   = 0;
    int            cyc      = 0;
    exp_t          q1[$];
    exp_t          q2[$];
    logic [DW-1:0] model_mem [DEPTH];
    bit            model_bad [DEPTH];
    bit            model_ready = 1'b0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    sram_dp_param #(.DW(DW), .AW(AW), .RD_LAT(1)) dut1 (
        .CLK(CLK), .RST(RST), .W(W), .R(R), .WA(WA), .RA(RA), .Din(Din),
        .Dout(Dout1), .Dvalid(Dvalid1), .Ready(Ready1), .Perr(Perr1)
    );

    sram_dp_param #(.DW(DW), .AW(AW), .RD_LAT(2)) dut2 (
        .CLK(CLK), .RST(RST), .W(W), .R(R), .WA(WA), .RA(RA), .Din(Din),
        .Dout(Dout2), .Dvalid(Dvalid2), .Ready(Ready2), .Perr(Perr2)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin : mon1
        exp_t e;
        if (Dvalid1) begin
            if (q1.size() == 0) begin
                check("lat1_unexpected_dvalid", Dvalid1, 1'b0);
            end else begin
                e = q1.pop_front();
                check("lat1_cycle", cyc, e.due);
                check("lat1_data", Dout1, e.data);
                check("lat1_perr", Perr1, e.perr);
            end
        end else if (Perr1) begin
            check("lat1_stray_perr", Perr1, 1'b0);
        end
    end

    always @(negedge CLK) begin : mon2
        exp_t e;
        if (Dvalid2) begin
            if (q2.size() == 0) begin
                check("lat2_unexpected_dvalid", Dvalid2, 1'b0);
            end else begin
                e = q2.pop_front();
                check("lat2_cycle", cyc, e.due);
                check("lat2_data", Dout2, e.data);
                check("lat2_perr", Perr2, e.perr);
            end
        end else if (Perr2) begin
            check("lat2_stray_perr", Perr2, 1'b0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One clock of stimulus; the read expectation is taken before this cycle's write lands.
    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] din,
                         input logic r, input logic [AW-1:0] ra);
        exp_t e;
        W = w; WA = wa; Din = din; R = r; RA = ra;
        if (model_ready && r) begin
            e.data = model_mem[ra];
            e.perr = model_bad[ra];
            e.due  = cyc + 2;
            q1.push_back(e);
            e.due  = cyc + 3;
            q2.push_back(e);
        end
        if (model_ready && w) begin
            model_mem[wa] = din;
            model_bad[wa] = 1'b0;
        end
        tick();
        W = 1'b0;
        R = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic drain();
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        tick();
        check("drain", q1.size() + q2.size(), 0);
    endtask

    task automatic apply_reset(input int cycles);
        RST = 1'b1; W = 1'b0; R = 1'b0;
        model_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = '0;
            model_bad[i] = 1'b0;
        end
        repeat (cycles) tick();
        check("rst_dout1", Dout1, '0);
        check("rst_dvalid1", Dvalid1, 1'b0);
        check("rst_ready1", Ready1, 1'b0);
        check("rst_perr1", Perr1, 1'b0);
        check("rst_dout2", Dout2, '0);
        check("rst_dvalid2", Dvalid2, 1'b0);
        check("rst_ready2", Ready2, 1'b0);
        check("rst_perr2", Perr2, 1'b0);
        RST = 1'b0;
    endtask

    // Counts edges from the last reset edge until Ready; inject > 0 fires one ignored W+R to address 5.
    task automatic wait_ready(input string tag, input int inject);
        int n = 0;
        while (Ready1 !== 1'b1 && n < 300) begin
            tick();
            n++;
            if (n == inject) begin
                W = 1'b1; WA = 7'd5; Din = '1; R = 1'b1; RA = 7'd5;
            end else begin
                W = 1'b0; R = 1'b0;
            end
        end
        check(tag, n, 128);
        check({tag, "_ready2"}, Ready2, 1'b1);
        model_ready = 1'b1;
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < DW / 32; i++) begin
            v[i*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [DW-1:0] pat_a5;
        RST = 1'b1; W = 1'b0; R = 1'b0; WA = '0; RA = '0; Din = '0;
        pat_a5 = {(DW / 8){8'hA5}};

        // Clear after a two-cycle reset, with an access attempted mid-clear
        apply_reset(2);
        wait_ready("clear_latency", 50);
        drive(1'b0, '0, '0, 1'b1, 7'd0);
        drive(1'b0, '0, '0, 1'b1, 7'd5);
        drive(1'b0, '0, '0, 1'b1, 7'd127);
        drain();

        // Basic write then read two cycles later
        drive(1'b1, 7'd3, pat_a5, 1'b0, '0);
        idle(1);
        drive(1'b0, '0, '0, 1'b1, 7'd3);
        drain();

        // Reset mid-clear restarts the sequence and wipes the earlier write
        apply_reset(1);
        repeat (60) tick();
        check("midclear_ready", Ready1, 1'b0);
        apply_reset(1);
        wait_ready("reclear_latency", 0);
        drive(1'b0, '0, '0, 1'b1, 7'd3);
        drain();

        // Collisions: read one cycle after write gets new data, same-cycle read gets old data
        d1 = rand_word();
        d2 = rand_word();
        drive(1'b1, 7'd10, d1, 1'b0, '0);
        drive(1'b0, '0, '0, 1'b1, 7'd10);
        drive(1'b1, 7'd20, d2, 1'b1, 7'd20);
        drive(1'b0, '0, '0, 1'b1, 7'd20);
        drain();

        // Back-to-back reads of a preloaded region, then Dout must hold
        drive(1'b1, 7'd1, DW'(8'h11), 1'b0, '0);
        drive(1'b1, 7'd2, DW'(8'h22), 1'b0, '0);
        drive(1'b1, 7'd3, DW'(8'h33), 1'b0, '0);
        drive(1'b0, '0, '0, 1'b1, 7'd1);
        drive(1'b0, '0, '0, 1'b1, 7'd2);
        drive(1'b0, '0, '0, 1'b1, 7'd3);
        drain();
        idle(4);
        check("hold_dout1", Dout1, DW'(8'h33));
        check("hold_dout2", Dout2, DW'(8'h33));
        check("idle_dvalid1", Dvalid1, 1'b0);
        check("idle_dvalid2", Dvalid2, 1'b0);

        // Random traffic over a narrow window plus the wrap-around addresses
        for (int i = 0; i < 300; i++) begin
            logic [AW-1:0] wa;
            logic [AW-1:0] ra;
            wa = AW'($urandom_range(0, 7)) - AW'(2);
            ra = AW'($urandom_range(0, 7)) - AW'(2);
            drive(1'($urandom_range(0, 1)), wa, rand_word(), 1'($urandom_range(0, 1)), ra);
        end
        drain();

`ifdef SRAM_DP_PARITY_EN
        // Corrupt one stored bit of a parity-protected word
        drive(1'b1, 7'd7, DW'(8'hFF), 1'b0, '0);
        idle(2);
        force dut1.r_mem[7][0] = 1'b0;
        force dut2.r_mem[7][0] = 1'b0;
        model_mem[7][0] = 1'b0;
        model_bad[7]    = 1'b1;
        drive(1'b0, '0, '0, 1'b1, 7'd7);
        drive(1'b0, '0, '0, 1'b1, 7'd8);
        drain();
        release dut1.r_mem[7][0];
        release dut2.r_mem[7][0];
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
